// File: rtl/pc_seq_pkg.sv
// Shared encodings for the PC sequencer: pc_sel codes, FSM states, default vectors.
package pc_seq_pkg;

    localparam int unsigned XLEN     = 32;
    localparam int unsigned PC_SEL_W = 2;

    localparam logic [PC_SEL_W-1:0] PC_SEL_SEQ  = 2'b00;
    localparam logic [PC_SEL_W-1:0] PC_SEL_BR   = 2'b01;
    localparam logic [PC_SEL_W-1:0] PC_SEL_JAL  = 2'b10;
    localparam logic [PC_SEL_W-1:0] PC_SEL_JALR = 2'b11;

    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        FETCH  = 2'b01,
        EXEC   = 2'b10,
        HALTED = 2'b11
    } state_e;

    localparam logic [XLEN-1:0] PC_RESET_DEFAULT    = 32'h0000_0000;
    localparam logic [XLEN-1:0] PC_TRAP_VEC_DEFAULT = 32'h0000_0100;

endpackage

// File: rtl/pc_sequencer_if.sv
// Decode/branch-compare and instruction-memory signals seen by the PC sequencer.
interface pc_sequencer_if;
    import pc_seq_pkg::*;

    logic [PC_SEL_W-1:0] pc_sel;
    logic                branch_taken;
    logic [XLEN-1:0]     imm;
    logic [XLEN-1:0]     rs1_value;
    logic                stall;
    logic                halt;
    logic                fetch_req;
    logic [XLEN-1:0]     fetch_addr;
    logic                fetch_ack;
    logic [XLEN-1:0]     pc;
    logic [XLEN-1:0]     pc4;
    logic                exec_valid;
    logic                retire;
    logic                trap;

    modport master (
        input  pc_sel, branch_taken, imm, rs1_value, stall, halt, fetch_ack,
        output fetch_req, fetch_addr, pc, pc4, exec_valid, retire, trap
    );

    modport slave (
        output pc_sel, branch_taken, imm, rs1_value, stall, halt, fetch_ack,
        input  fetch_req, fetch_addr, pc, pc4, exec_valid, retire, trap
    );

endinterface

// File: rtl/next_pc_calc.sv
// Next-PC candidate adders: sequential, PC-relative and register-indirect targets.
module next_pc_calc
    import pc_seq_pkg::*;
(
    input  logic [XLEN-1:0] pc,
    input  logic [XLEN-1:0] imm,
    input  logic [XLEN-1:0] rs1_value,
    output logic [XLEN-1:0] pc4_c,
    output logic [XLEN-1:0] pc_imm_c,
    output logic [XLEN-1:0] jalr_tgt_c
);

    // All sums wrap modulo 2^32; JALR target has bit0 forced low.
    assign pc4_c      = pc + XLEN'(4);
    assign pc_imm_c   = pc + imm;
    assign jalr_tgt_c = (rs1_value + imm) & 32'hFFFF_FFFE;

endmodule

// File: rtl/pc_sequencer.sv
// Architectural PC register and fetch/execute/commit sequencer for the RV32I core.
// Optional misaligned-redirect trap enabled by defining PC_MISALIGN_TRAP_EN.
module pc_sequencer
    import pc_seq_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC = PC_RESET_DEFAULT,
    parameter logic [XLEN-1:0] TRAP_VEC = PC_TRAP_VEC_DEFAULT
) (
    input  logic            clk,
    input  logic            rst,
    pc_sequencer_if.master  bus
);

    state_e          state_q, state_d;
    logic [XLEN-1:0] pc_q, pc_d;
    logic            fetch_req_q, fetch_req_d;
    logic            exec_valid_q, exec_valid_d;
    logic            retire_q, retire_d;
    logic            trap_q, trap_d;

    logic            commit_c;
    logic            redirect_c;
    logic [XLEN-1:0] npc_c;
    logic [XLEN-1:0] pc4_c;
    logic [XLEN-1:0] pc_imm_c;
    logic [XLEN-1:0] jalr_tgt_c;

    next_pc_calc u_next_pc_calc (
        .pc         (pc_q),
        .imm        (bus.imm),
        .rs1_value  (bus.rs1_value),
        .pc4_c      (pc4_c),
        .pc_imm_c   (pc_imm_c),
        .jalr_tgt_c (jalr_tgt_c)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        commit_c = 1'b0;
        case (state_q)
            IDLE:   state_d = FETCH;
            FETCH:  if (bus.fetch_ack) state_d = EXEC;
            EXEC: begin
                if (!bus.stall) begin
                    commit_c = 1'b1;
                    state_d  = bus.halt ? HALTED : FETCH;
                end
            end
            HALTED: state_d = HALTED;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        npc_c      = pc4_c;
        redirect_c = 1'b0;
        case (bus.pc_sel)
            PC_SEL_BR: begin
                if (bus.branch_taken) begin
                    npc_c      = pc_imm_c;
                    redirect_c = 1'b1;
                end
            end
            PC_SEL_JAL: begin
                npc_c      = pc_imm_c;
                redirect_c = 1'b1;
            end
            PC_SEL_JALR: begin
                npc_c      = jalr_tgt_c;
                redirect_c = 1'b1;
            end
            default: npc_c = pc4_c;
        endcase

        pc_d         = pc_q;
        trap_d       = 1'b0;
        retire_d     = commit_c;
        fetch_req_d  = (state_d == FETCH);
        exec_valid_d = (state_d == EXEC);
        if (commit_c) begin
            pc_d = npc_c;
`ifdef PC_MISALIGN_TRAP_EN
            if (redirect_c && npc_c[1]) begin
                pc_d   = TRAP_VEC;
                trap_d = 1'b1;
            end
`endif
        end
    end

`ifndef PC_MISALIGN_TRAP_EN
    logic unused_trap_cfg;
    assign unused_trap_cfg = redirect_c ^ (^TRAP_VEC);
`endif

    // Strobes are registered from the next state, so they line up with the state they describe.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc_q         <= RESET_PC;
            fetch_req_q  <= 1'b0;
            exec_valid_q <= 1'b0;
            retire_q     <= 1'b0;
            trap_q       <= 1'b0;
        end else begin
            pc_q         <= pc_d;
            fetch_req_q  <= fetch_req_d;
            exec_valid_q <= exec_valid_d;
            retire_q     <= retire_d;
            trap_q       <= trap_d;
        end
    end

    assign bus.pc         = pc_q;
    assign bus.fetch_addr = pc_q;
    assign bus.pc4        = pc4_c;
    assign bus.fetch_req  = fetch_req_q;
    assign bus.exec_valid = exec_valid_q;
    assign bus.retire     = retire_q;
    assign bus.trap       = trap_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// Scoreboard bench for pc_sequencer: driver queues expected commits, monitor checks each retire.
module tb_pc_sequencer;
    import pc_seq_pkg::*;

    typedef struct {
        logic [31:0] pc;
        logic        trap;
        int          gap;
        int          id;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    int   n_checks = 0;
    int   n_fail   = 0;
    int   cyc      = 0;
    int   last_cyc = 0;
    exp_t sb[$];
    exp_t e;

    pc_sequencer_if bus ();

    pc_sequencer dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s actual=%08h expected=%08h t=%0t", nm, act, exp, $time);
        end
    endtask

    // Monitor: every retire pops one expected commit.
    always @(negedge clk) begin
        if (rst === 1'b0) begin
            if (bus.retire === 1'b1) begin
                if (sb.size() == 0) begin
                    check("unexpected_retire", 32'(bus.retire), 32'd0);
                end else begin
                    e = sb.pop_front();
                    check($sformatf("retire_pc_%0d", e.id), bus.pc, e.pc);
                    check($sformatf("retire_trap_%0d", e.id), 32'(bus.trap), 32'(e.trap));
                    if (e.gap > 0)
                        check($sformatf("retire_gap_%0d", e.id), 32'(cyc - last_cyc), 32'(e.gap));
                end
                last_cyc = cyc;
            end else if (bus.trap !== 1'b0) begin
                check("trap_without_retire", 32'(bus.trap), 32'd0);
            end
        end
    end

    task automatic clear_inputs();
        bus.pc_sel       = PC_SEL_SEQ;
        bus.branch_taken = 1'b0;
        bus.imm          = 32'h0;
        bus.rs1_value    = 32'h0;
        bus.stall        = 1'b0;
        bus.halt         = 1'b0;
        bus.fetch_ack    = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        clear_inputs();
        repeat (2) @(negedge clk);
        check("rst_pc", bus.pc, 32'h0);
        check("rst_fetch_req", 32'(bus.fetch_req), 32'd0);
        check("rst_exec_valid", 32'(bus.exec_valid), 32'd0);
        check("rst_retire", 32'(bus.retire), 32'd0);
        check("rst_trap", 32'(bus.trap), 32'd0);
        rst = 1'b0;
        check("idle_no_req", 32'(bus.fetch_req), 32'd0);
        @(negedge clk);
        check("first_fetch_req", 32'(bus.fetch_req), 32'd1);
        check("first_fetch_addr", bus.fetch_addr, 32'h0);
    endtask

    task automatic run_instr(input logic [1:0] sel, input logic bt, input logic [31:0] im,
                             input logic [31:0] rs1, input int ack_dly, input int stall_n,
                             input logic hlt, input logic [31:0] start_pc,
                             input logic [31:0] exp_pc, input logic exp_trap,
                             input int gap, input int id);
        int guard = 0;
        while (bus.fetch_req !== 1'b1 && guard < 20) begin
            @(negedge clk);
            guard++;
        end
        check($sformatf("fetch_req_%0d", id), 32'(bus.fetch_req), 32'd1);
        check($sformatf("fetch_addr_%0d", id), bus.fetch_addr, start_pc);
        bus.pc_sel       = sel;
        bus.branch_taken = bt;
        bus.imm          = im;
        bus.rs1_value    = rs1;
        bus.stall        = 1'b0;
        bus.halt         = 1'b0;
        for (int i = 0; i < ack_dly; i++) begin
            @(negedge clk);
            check($sformatf("wait_req_%0d", id), 32'(bus.fetch_req), 32'd1);
            check($sformatf("wait_addr_%0d", id), bus.fetch_addr, start_pc);
            check($sformatf("wait_exec_%0d", id), 32'(bus.exec_valid), 32'd0);
        end
        bus.fetch_ack = 1'b1;
        @(negedge clk);
        bus.fetch_ack = 1'b0;
        check($sformatf("exec_valid_%0d", id), 32'(bus.exec_valid), 32'd1);
        check($sformatf("exec_no_req_%0d", id), 32'(bus.fetch_req), 32'd0);
        check($sformatf("link_pc4_%0d", id), bus.pc4, start_pc + 32'd4);
        bus.halt = hlt;
        for (int i = 0; i < stall_n; i++) begin
            bus.stall = 1'b1;
            @(negedge clk);
            check($sformatf("stall_exec_%0d", id), 32'(bus.exec_valid), 32'd1);
            check($sformatf("stall_pc_%0d", id), bus.pc, start_pc);
        end
        bus.stall = 1'b0;
        sb.push_back('{pc: exp_pc, trap: exp_trap, gap: gap, id: id});
        @(negedge clk);
        bus.halt = 1'b0;
    endtask

    initial begin
        int guard;
        rst = 1'b1;
        clear_inputs();
        do_reset();

        // Sequential run, back-to-back, then a 3-cycle fetch wait.
        run_instr(PC_SEL_SEQ,  1'b0, 32'h0,         32'h0,         0, 0, 1'b0, 32'h0000_0000, 32'h0000_0004, 1'b0, 0, 1);
        run_instr(PC_SEL_SEQ,  1'b0, 32'h0,         32'h0,         0, 0, 1'b0, 32'h0000_0004, 32'h0000_0008, 1'b0, 2, 2);
        run_instr(PC_SEL_SEQ,  1'b0, 32'h0,         32'h0,         3, 0, 1'b0, 32'h0000_0008, 32'h0000_000C, 1'b0, 0, 3);
        run_instr(PC_SEL_JAL,  1'b0, 32'h4,         32'h0,         0, 0, 1'b0, 32'h0000_000C, 32'h0000_0010, 1'b0, 0, 4);
        // Branch taken/not taken from 0x10.
        run_instr(PC_SEL_BR,   1'b1, 32'hFFFF_FFF8, 32'h0,         0, 0, 1'b0, 32'h0000_0010, 32'h0000_0008, 1'b0, 0, 5);
        run_instr(PC_SEL_JAL,  1'b0, 32'h8,         32'h0,         0, 0, 1'b0, 32'h0000_0008, 32'h0000_0010, 1'b0, 0, 6);
        run_instr(PC_SEL_BR,   1'b0, 32'hFFFF_FFF8, 32'h0,         1, 0, 1'b0, 32'h0000_0010, 32'h0000_0014, 1'b0, 0, 7);
        // JALR with two stall cycles; bit0 of the sum is cleared.
        run_instr(PC_SEL_JALR, 1'b0, 32'h4,         32'h0000_1001, 0, 2, 1'b0, 32'h0000_0014, 32'h0000_1004, 1'b0, 0, 8);
        run_instr(PC_SEL_JALR, 1'b0, 32'hC,         32'hFFFF_FFF0, 0, 0, 1'b0, 32'h0000_1004, 32'hFFFF_FFFC, 1'b0, 0, 9);
        // Wrap to zero, then halt (held off by stall for one cycle).
        run_instr(PC_SEL_SEQ,  1'b0, 32'h0,         32'h0,         0, 0, 1'b0, 32'hFFFF_FFFC, 32'h0000_0000, 1'b0, 0, 10);
        run_instr(PC_SEL_SEQ,  1'b0, 32'h0,         32'h0,         0, 1, 1'b1, 32'h0000_0000, 32'h0000_0004, 1'b0, 0, 11);

        for (int i = 0; i < 6; i++) begin
            bus.fetch_ack = i[0];
            @(negedge clk);
            check("halted_req", 32'(bus.fetch_req), 32'd0);
            check("halted_exec", 32'(bus.exec_valid), 32'd0);
            check("halted_pc", bus.pc, 32'h0000_0004);
        end
        bus.fetch_ack = 1'b0;

        // Reset mid-FETCH drops fetch_req without waiting for a clock.
        do_reset();
        #2 rst = 1'b1;
        #1 check("abort_fetch_req", 32'(bus.fetch_req), 32'd0);

        // Reset mid-EXEC: no retire, pc back to reset value.
        do_reset();
        run_instr(PC_SEL_SEQ, 1'b0, 32'h0, 32'h0, 0, 0, 1'b0, 32'h0, 32'h4, 1'b0, 0, 12);
        bus.fetch_ack = 1'b1;
        @(negedge clk);
        bus.fetch_ack = 1'b0;
        check("pre_abort_exec", 32'(bus.exec_valid), 32'd1);
        #1 rst = 1'b1;
        #1;
        check("abort_exec_valid", 32'(bus.exec_valid), 32'd0);
        check("abort_pc", bus.pc, 32'h0);

        // Misaligned JAL target.
        do_reset();
`ifdef PC_MISALIGN_TRAP_EN
        run_instr(PC_SEL_JAL, 1'b0, 32'h6, 32'h0, 0, 0, 1'b0, 32'h0, 32'h0000_0100, 1'b1, 0, 13);
`else
        run_instr(PC_SEL_JAL, 1'b0, 32'h6, 32'h0, 0, 0, 1'b0, 32'h0, 32'h0000_0006, 1'b0, 0, 13);
`endif
        @(negedge clk);
        check("trap_one_cycle", 32'(bus.trap), 32'd0);

        guard = 0;
        while (sb.size() != 0 && guard < 10) begin
            @(negedge clk);
            guard++;
        end
        check("scoreboard_drained", 32'(sb.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog_timeout actual=running expected=finished");
        $fatal(1, "watchdog");
    end

endmodule
